// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and defaults for the ALU op sequencer.
//   seq_state_t : IDLE / ISSUE / RESP sequencer states
//   DATA_W_DEF  : default operand/result width
//   SEL_W_DEF   : default ALU select width
//   STATE_W     : encoded state width
package alu_seq_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 4;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;
endpackage

// File: rtl/alu_seq_lat_counter.sv
// alu_seq_lat_counter: settle-time counter for the ALU operand drive.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (asserted on ISSUE entry)
//   en         : count while the sequencer sits in ISSUE
//   done       : one-cycle pulse, registered one cycle after cnt reaches ALU_LAT-1
module alu_seq_lat_counter #(
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ALU_LAT - 1);

    logic [CNT_W-1:0] cnt;

    // done is registered, so capture happens ALU_LAT+1 edges after accept.
    // The !done term keeps it a single pulse even though cnt parks at LAST.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            if (cnt != LAST)
                cnt <= cnt + CNT_W'(1);
            done <= (cnt == LAST) && !done;
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issuing end of an external ALU (A, B, ALU_Sel -> Out, Carry).
//   req_*  : valid/ready op request (operands, select, sweep flag)
//   alu_*  : registered operands/select to the ALU, result/carry back from it
//   rsp_*  : valid/ready response (result, carry, producing select, last flag)
//   busy   : sequencer not idle
// Sweep mode issues NUM_OPS consecutive selects (wrapping) for one operand pair.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int ALU_LAT = 1,
    parameter int NUM_OPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              req_sweep,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic              rsp_last,
    output logic              busy
);
    localparam int OPS_W = $clog2(NUM_OPS + 1);
    localparam logic [OPS_W-1:0] OPS_LAST = OPS_W'(NUM_OPS - 1);

    seq_state_t       state, state_next;
    logic [OPS_W-1:0] ops_left;
    logic             lat_done;
    logic             lat_clr;

    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign lat_clr   = (state != ISSUE) && (state_next == ISSUE);

    alu_seq_lat_counter #(.ALU_LAT(ALU_LAT)) u_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lat_clr),
        .en    (state == ISSUE),
        .done  (lat_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   if (lat_done)  state_next = RESP;
            RESP:    if (rsp_ready) state_next = (ops_left == '0) ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    // Operand and response registers. rsp_valid is always 1 in RESP, so the
    // handshake reduces to rsp_ready there; fields hold until it arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            ops_left   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_sel    <= '0;
            rsp_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    alu_a    <= req_a;
                    alu_b    <= req_b;
                    alu_sel  <= req_sel;
                    ops_left <= req_sweep ? OPS_LAST : '0;
                end
                ISSUE: if (lat_done) begin
                    rsp_result <= alu_out;
                    rsp_carry  <= alu_carry;
                    rsp_sel    <= alu_sel;
                    rsp_last   <= (ops_left == '0);
                    rsp_valid  <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    if (ops_left != '0) begin
                        alu_sel  <= alu_sel + SEL_W'(1);   // wraps mod 2**SEL_W
                        ops_left <= ops_left - OPS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // ALU_LAT=1 instance
    logic        req_valid, req_ready, req_sweep;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_result;
    logic [3:0]  req_sel, alu_sel, rsp_sel;
    logic        alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_last, busy;

    // ALU_LAT=3 instance
    logic        req_valid3, req_ready3, req_sweep3;
    logic [31:0] req_a3, req_b3, alu_a3, alu_b3, alu_out3, rsp_result3;
    logic [3:0]  req_sel3, alu_sel3, rsp_sel3;
    logic        alu_carry3, rsp_valid3, rsp_ready3, rsp_carry3, rsp_last3, busy3;

    // stub ALU: out = a + b + sel, carry = a[0]
    assign alu_out    = alu_a + alu_b + 32'(alu_sel);
    assign alu_carry  = alu_a[0];
    assign alu_out3   = alu_a3 + alu_b3 + 32'(alu_sel3);
    assign alu_carry3 = alu_a3[0];

    alu_op_sequencer #(.DATA_W(32), .SEL_W(4), .ALU_LAT(1), .NUM_OPS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_sweep(req_sweep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_sel(rsp_sel), .rsp_last(rsp_last), .busy(busy)
    );

    alu_op_sequencer #(.DATA_W(32), .SEL_W(4), .ALU_LAT(3), .NUM_OPS(16)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3), .req_b(req_b3),
        .req_sel(req_sel3), .req_sweep(req_sweep3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_out(alu_out3), .alu_carry(alu_carry3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .rsp_carry(rsp_carry3),
        .rsp_sel(rsp_sel3), .rsp_last(rsp_last3), .busy(busy3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the ALU_LAT=1 instance and drain all responses.
    // bp: 0 = always ready, 1 = random ready, 2 = 5-cycle stall per response.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic sweep, input int bp);
        int n, got, cyc, lat, stall;
        bit first, snap;
        logic [31:0] s_res;
        logic [3:0]  s_sel, s_asel;
        logic        s_carry, s_last;
        logic [3:0]  e_sel;
        logic [31:0] e_res;

        n = sweep ? 16 : 1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_sweep = sweep;
        rsp_ready = (bp == 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("alu_a_latched", alu_a, a);
        chk("alu_b_latched", alu_b, b);
        chk("alu_sel_latched", alu_sel, sel);

        got = 0; cyc = 0; lat = 0; stall = 0; first = 1'b1; snap = 1'b0;
        while (got < n && cyc < 600) begin
            // rsp_ready chosen here applies at the coming posedge
            case (bp)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = (stall >= 5);
            endcase
            if (rsp_valid) begin
                if (first) begin
                    chk("first_latency", 64'(lat), 64'd2);
                    first = 1'b0;
                end
                e_sel = 4'((int'(sel) + got) % 16);
                e_res = a + b + 32'(e_sel);
                if (rsp_ready) begin
                    chk("rsp_sel", rsp_sel, e_sel);
                    chk("rsp_result", rsp_result, e_res);
                    chk("rsp_carry", rsp_carry, a[0]);
                    chk("rsp_last", rsp_last, (got == n - 1));
                    chk("alu_sel_in_resp", alu_sel, e_sel);
                    got++;
                    stall = 0;
                end else begin
                    snap = 1'b1;
                    s_res = rsp_result; s_sel = rsp_sel; s_carry = rsp_carry;
                    s_last = rsp_last; s_asel = alu_sel;
                    stall++;
                end
            end
            @(negedge clk);
            cyc++;
            if (first) lat++;
            if (snap) begin
                snap = 1'b0;
                chk("hold_valid", rsp_valid, 1'b1);
                chk("hold_result", rsp_result, s_res);
                chk("hold_sel", rsp_sel, s_sel);
                chk("hold_carry", rsp_carry, s_carry);
                chk("hold_last", rsp_last, s_last);
                chk("hold_alu_sel", alu_sel, s_asel);
            end
        end
        chk("rsp_count", 64'(got), 64'(n));
        chk("valid_drop_after_last", rsp_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_req_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;
    endtask

    initial begin
        int got, cyc, lat;
        rst_n = 1'b0;
        req_valid = 0; req_a = 0; req_b = 0; req_sel = 0; req_sweep = 0; rsp_ready = 0;
        req_valid3 = 0; req_a3 = 0; req_b3 = 0; req_sel3 = 0; req_sweep3 = 0; rsp_ready3 = 0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_sel", alu_sel, 4'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1'b1);

        // single op, sweep, backpressure, wrap
        do_req(32'h0A, 32'h02, 4'h3, 1'b0, 0);
        do_req(32'h0A, 32'h02, 4'h0, 1'b1, 0);
        do_req(32'h1234_5677, 32'h0000_0100, 4'h9, 1'b0, 2);
        do_req(32'hF6, 32'h0A, 4'hE, 1'b1, 0);

        // randomized requests with random backpressure
        for (int i = 0; i < 6; i++)
            do_req($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);

        // reset mid-sweep after the third response handshake
        req_valid = 1'b1; req_a = 32'h55; req_b = 32'h3; req_sel = 4'h2; req_sweep = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        got = 0; cyc = 0;
        while (got < 3 && cyc < 100) begin
            if (rsp_valid) got++;
            @(negedge clk);
            cyc++;
        end
        chk("mid_sweep_rsps", 64'(got), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        chk("midrst_alu_sel", alu_sel, 4'd0);
        chk("midrst_req_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(32'h77, 32'h11, 4'h4, 1'b0, 0);

        // ALU_LAT=3: single op latency, request held while busy is ignored
        rsp_ready3 = 1'b1;
        req_valid3 = 1'b1; req_a3 = 32'h11; req_b3 = 32'h22; req_sel3 = 4'h5; req_sweep3 = 1'b0;
        chk("lat3_req_ready", req_ready3, 1'b1);
        @(negedge clk);
        req_a3 = 32'h99; req_b3 = 32'h1; req_sel3 = 4'h0;   // still valid while busy
        lat = 0;
        while (!rsp_valid3 && lat < 20) begin
            chk("lat3_busy_not_ready", req_ready3, 1'b0);
            chk("lat3_alu_a_hold", alu_a3, 32'h11);
            @(negedge clk);
            lat++;
        end
        chk("lat3_latency", 64'(lat), 64'd4);
        chk("lat3_result", rsp_result3, 32'h38);
        chk("lat3_sel", rsp_sel3, 4'h5);
        chk("lat3_last", rsp_last3, 1'b1);
        chk("lat3_carry", rsp_carry3, 1'b1);
        req_valid3 = 1'b0;
        @(negedge clk);
        chk("lat3_valid_drop", rsp_valid3, 1'b0);
        chk("lat3_idle", busy3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
